// File: rtl/line_fill_responder_if.sv
// rtl/line_fill_responder_if.sv - cache refill request/response and 32-bit memory bus signals
interface line_fill_responder_if;
    logic [31:0]  addr_i;
    logic         rd_i;
    logic [255:0] data_o;
    logic         ack_o;
    logic         page_fault_o;
    logic [31:0]  mem_addr_o;
    logic         mem_rd_o;
    logic [31:0]  mem_data_i;
    logic         mem_ack_i;
    logic         mem_fault_i;

    modport slave (
        input  addr_i, rd_i, mem_data_i, mem_ack_i, mem_fault_i,
        output data_o, ack_o, page_fault_o, mem_addr_o, mem_rd_o
    );

    modport master (
        output addr_i, rd_i, mem_data_i, mem_ack_i, mem_fault_i,
        input  data_o, ack_o, page_fault_o, mem_addr_o, mem_rd_o
    );
endinterface

// File: rtl/line_fill_responder.sv
// rtl/line_fill_responder.sv - fetches a 256-bit line as eight 32-bit memory reads and acks it
module line_fill_responder #(
    parameter logic [31:0] ADDR_LIMIT = 32'h1000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    line_fill_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   data_q, data_d;
    logic           ack_q, ack_d;
    logic           pf_q, pf_d;
    logic           fault_q, fault_d;
    logic [31:0]    addr_q, addr_d;
    logic           rd_q, rd_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [31:0]    line_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            ack_q   <= 1'b0;
            pf_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
            pf_q    <= pf_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // ack/page_fault are registered, so they are raised on the transition into RESP
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ack_d     = 1'b0;
        pf_d      = 1'b0;
        fault_d   = fault_q;
        addr_d    = addr_q;
        rd_d      = rd_q;
        cnt_d     = cnt_q;
        line_base = {bus.addr_i[31:5], 5'b00000};

        case (state_q)
            IDLE: begin
                if (bus.rd_i) begin
                    data_d = '0;
                    if (line_base >= ADDR_LIMIT) begin
                        fault_d = 1'b1;
                        ack_d   = 1'b1;
                        pf_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        addr_d  = line_base;
                        rd_d    = 1'b1;
                        cnt_d   = 3'd0;
                        fault_d = 1'b0;
                        state_d = FETCH;
                    end
                end
            end

            FETCH: begin
                if (bus.mem_ack_i) begin
                    data_d[{cnt_q, 5'b00000} +: 32] = bus.mem_data_i;
                    if (bus.mem_fault_i) begin
                        fault_d = 1'b1;
                        rd_d    = 1'b0;
                        ack_d   = 1'b1;
                        pf_d    = 1'b1;
                        state_d = RESP;
                    end else if (cnt_q == 3'd7) begin
                        rd_d    = 1'b0;
                        ack_d   = 1'b1;
                        pf_d    = fault_q;
                        state_d = RESP;
                    end else begin
                        // only the word-select bits move; the line base stays put
                        cnt_d  = cnt_q + 3'd1;
                        addr_d = {addr_q[31:5], cnt_q + 3'd1, 2'b00};
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.data_o       = data_q;
    assign bus.ack_o        = ack_q;
    assign bus.page_fault_o = pf_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_rd_o     = rd_q;

endmodule
